vc_output_arbiter: RTL

Output-port controller for one mesh router link. It shares a single output channel between NUM_REQ input-VC requesters using round-robin arbitration, one arbiter per virtual channel. It holds one packet per VC in an internal output slot and drives the downstream link with the same so/ro/do handshake and even/odd polarity scheme the NIC uses. It also owns the link polarity register, so the NIC and the neighbouring router ports can share its polarity.

---
 rtl/noc_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 80 ++++++++
 rtl/vc_output_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the router output-port logic.
// Packets are declared [0:PACKET_SIZE-1]; bit VC_BIT (0) selects the VC.
package noc_pkg;

    // Default packet width in bits
    localparam int PACKET_SIZE = 64;

    // Position of the virtual-channel bit inside a packet
    localparam int VC_BIT = 0;

    // Virtual channel identifier: 0 = even, 1 = odd
    typedef logic vc_t;

    localparam vc_t VC_EVEN = 1'b0;
    localparam vc_t VC_ODD  = 1'b1;

endpackage : noc_pkg

// File: rtl/rr_arbiter.sv
// rr_arbiter: single-VC arbiter for the output-port controller.
// Default build: round-robin with a rotating pointer (first requester at or
// after the pointer wins; the pointer moves past the winner on a grant).
// Build option RR_ARB_FIXED_PRIO_EN: lowest requesting index wins and no
// pointer register is built.
// gnt/valid are combinational and stay low while enable is low.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:NUM_REQ-1] req,
    input  logic               enable,
    output logic [0:NUM_REQ-1] gnt,
    output logic               valid
);

`ifdef RR_ARB_FIXED_PRIO_EN

    // Fixed priority keeps no state, so the clock and reset are not needed.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    // Lowest eligible index wins
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        if (enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i]) begin
                    gnt[i] = 1'b1;
                    valid  = 1'b1;
                end
            end
        end
    end

`else

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Two passes: indices at or after the pointer first, then the wrap to 0.
    // The pointer only advances when a grant is actually issued.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        ptr_d = ptr_q;
        if (enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && (i >= int'(ptr_q)) && req[i]) begin
                    gnt[i] = 1'b1;
                    valid  = 1'b1;
                    ptr_d  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i]) begin
                    gnt[i] = 1'b1;
                    valid  = 1'b1;
                    ptr_d  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule : rr_arbiter

// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: output-port controller for one mesh router link.
// Holds one packet per VC. Each cycle the VC equal to the polarity is refilled
// from the requesters (one arbiter per VC) while the other VC's slot drives
// the link with the so/ro/do handshake. Since fill and drain never touch the
// same VC in one cycle, there is no bypass path.
// Build option RR_ARB_FIXED_PRIO_EN switches both arbiters to fixed priority.
module vc_output_arbiter #(
    parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE,
    parameter int NUM_REQ     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [0:NUM_REQ-1]             req,
    input  logic [0:NUM_REQ*PACKET_SIZE-1] req_data,
    output logic [0:NUM_REQ-1]             gnt,
    output logic                           out_so,
    input  logic                           out_ro,
    output logic [0:PACKET_SIZE-1]         out_do,
    output logic                           polarity
);

    import noc_pkg::*;

    vc_t                    pol_q;
    logic [1:0]             slot_full_q;
    logic [1:0]             slot_full_d;
    logic [0:PACKET_SIZE-1] slot_data_q [2];
    logic [0:PACKET_SIZE-1] slot_data_d [2];

    vc_t                    fill_vc;
    vc_t                    send_vc;
    logic [0:NUM_REQ-1]     elig_even;
    logic [0:NUM_REQ-1]     elig_odd;
    logic [0:NUM_REQ-1]     gnt_even;
    logic [0:NUM_REQ-1]     gnt_odd;
    logic                   vld_even;
    logic                   vld_odd;
    logic                   en_even;
    logic                   en_odd;
    logic                   fill_vld;
    logic [0:PACKET_SIZE-1] fill_pkt;

    assign fill_vc  = pol_q;
    assign send_vc  = ~pol_q;
    assign polarity = pol_q;

    // Split requesters by the VC bit of the packet they are offering
    always_comb begin
        elig_even = '0;
        elig_odd  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_data[i*PACKET_SIZE + VC_BIT] == VC_ODD) begin
                elig_odd[i] = req[i];
            end else begin
                elig_even[i] = req[i];
            end
        end
    end

    // Only the VC matching this cycle's polarity may fill, and only into an
    // empty slot; reset suppresses all grants.
    assign en_even = ~reset & ~slot_full_q[VC_EVEN] & (fill_vc == VC_EVEN);
    assign en_odd  = ~reset & ~slot_full_q[VC_ODD]  & (fill_vc == VC_ODD);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb_even (
        .clk    (clk),
        .reset  (reset),
        .req    (elig_even),
        .enable (en_even),
        .gnt    (gnt_even),
        .valid  (vld_even)
    );

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb_odd (
        .clk    (clk),
        .reset  (reset),
        .req    (elig_odd),
        .enable (en_odd),
        .gnt    (gnt_odd),
        .valid  (vld_odd)
    );

    // At most one arbiter is enabled per cycle, so OR-ing the grants is safe
    assign gnt      = gnt_even | gnt_odd;
    assign fill_vld = vld_even | vld_odd;

    // Select the granted requester's packet for the fill slot
    always_comb begin
        fill_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fill_pkt = req_data[i*PACKET_SIZE +: PACKET_SIZE];
            end
        end
    end

    // Link side: the slot of the opposite VC is offered downstream
    assign out_do = slot_data_q[send_vc];
    assign out_so = slot_full_q[send_vc] & out_ro & ~reset;

    // Slot next state: drain the send VC, fill the polarity VC
    always_comb begin
        slot_full_d = slot_full_q;
        slot_data_d = slot_data_q;
        if (out_so) begin
            slot_full_d[send_vc] = 1'b0;
        end
        if (fill_vld) begin
            slot_full_d[fill_vc] = 1'b1;
            slot_data_d[fill_vc] = fill_pkt;
        end
    end

    // Polarity and slot registers; reset empties both slots and clears data
    always_ff @(posedge clk) begin
        if (reset) begin
            pol_q          <= VC_EVEN;
            slot_full_q    <= '0;
            slot_data_q[0] <= '0;
            slot_data_q[1] <= '0;
        end else begin
            pol_q          <= ~pol_q;
            slot_full_q    <= slot_full_d;
            slot_data_q[0] <= slot_data_d[0];
            slot_data_q[1] <= slot_data_d[1];
        end
    end

endmodule : vc_output_arbiter
